icache_line_adapter: RTL and testbench

- Sits directly downstream of the instruction-cache controller's DFP port.
- Converts one full-line DFP read or write (LINE_WIDTH bits, held request / single-cycle response) into a fixed-length burst of BURST_WIDTH-bit beats on the backing-memory port.
- Assembles read beats into a line and returns it with a one-cycle dfp_resp.
- Serialises write lines into beats.
- Handles one line transaction at a time, with no outstanding requests.

---
 rtl/cache_types.sv | 18 +
 rtl/icache_line_adapter.sv | 141 ++++++++++++++
 tb/tb_icache_line_adapter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_types.sv
// Types and constants shared between the instruction-cache controller and its
// line-to-burst adapter.
package cache_types;

    localparam int LINE_WIDTH  = 256;
    localparam int BURST_WIDTH = 64;
    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;

    // Suffixed literals keep clear of the controller's own IDLE/DONE states.
    typedef enum logic [2:0] {
        IDLE_A,
        RD_CMD,
        RD_BEAT,
        WR_BEAT,
        DONE_A
    } adapter_state_t;

endpackage

// File: rtl/icache_line_adapter.sv
// Converts one full-line cache DFP read/write into a fixed-length burst of
// memory beats; read beats are assembled back into a line.
//
// state   | meaning
// IDLE_A  | waiting for a line request (write has priority)
// RD_CMD  | burst read command presented until memory accepts it
// RD_BEAT | collecting read beats in order, lowest beat first
// WR_BEAT | presenting write beat r_cnt until accepted
// DONE_A  | one-cycle dfp_resp, request not re-sampled
module icache_line_adapter
    import cache_types::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  dfp_addr,
    input  logic                   dfp_read,
    input  logic                   dfp_write,
    input  logic [LINE_WIDTH-1:0]  dfp_wdata,
    output logic [LINE_WIDTH-1:0]  dfp_rdata,
    output logic                   dfp_resp,
    output logic [ADDR_WIDTH-1:0]  bmem_addr,
    output logic                   bmem_read,
    output logic                   bmem_write,
    output logic [BURST_WIDTH-1:0] bmem_wdata,
    input  logic                   bmem_ready,
    input  logic [BURST_WIDTH-1:0] bmem_rdata,
    input  logic                   bmem_rvalid
);

    localparam int BEATS      = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_BYTES = LINE_WIDTH / 8;

    adapter_state_t          r_state;
    adapter_state_t          w_next_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LINE_WIDTH-1:0]   r_wline;
    logic [LINE_WIDTH-1:0]   r_rdata;
    logic [ADDR_WIDTH-1:0]   w_line_addr;
    logic                    w_last;
    logic [BURST_WIDTH-1:0]  w_slice;

    assign w_line_addr = dfp_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
    assign w_last      = (r_cnt == CNT_W'(BEATS - 1));
    assign w_slice     = r_wline[int'(r_cnt) * BURST_WIDTH +: BURST_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE_A: begin
                if (dfp_write) begin
                    w_next_state = WR_BEAT;
                end else if (dfp_read) begin
                    w_next_state = RD_CMD;
                end
            end
            RD_CMD: begin
                if (bmem_ready) begin
                    w_next_state = RD_BEAT;
                end
            end
            RD_BEAT: begin
                if (bmem_rvalid && w_last) begin
                    w_next_state = DONE_A;
                end
            end
            WR_BEAT: begin
                if (bmem_ready && w_last) begin
                    w_next_state = DONE_A;
                end
            end
            DONE_A:  w_next_state = IDLE_A;
            default: w_next_state = IDLE_A;
        endcase
    end

    always_comb begin
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        dfp_resp   = 1'b0;
        case (r_state)
            RD_CMD:  bmem_read  = 1'b1;
            WR_BEAT: bmem_write = 1'b1;
            DONE_A:  dfp_resp   = 1'b1;
            default: ;
        endcase
    end

    assign bmem_addr  = r_addr;
    assign bmem_wdata = w_slice;
    assign dfp_rdata  = r_rdata;

    // Counter only wraps on the last beat, so a non-power-of-two BEATS still works.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wline <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE_A: begin
                    if (dfp_write) begin
                        r_addr  <= w_line_addr;
                        r_wline <= dfp_wdata;
                        r_cnt   <= '0;
                    end else if (dfp_read) begin
                        r_addr <= w_line_addr;
                        r_cnt  <= '0;
                    end
                end
                RD_BEAT: begin
                    if (bmem_rvalid) begin
                        r_rdata[int'(r_cnt) * BURST_WIDTH +: BURST_WIDTH] <= bmem_rdata;
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    end
                end
                WR_BEAT: begin
                    if (bmem_ready) begin
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_line_adapter.sv
// Directed bench for icache_line_adapter: drivers push expected commands, beats
// and responses into queues; a negedge monitor pops and compares.
module tb_icache_line_adapter;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int BW = 64;
    localparam int NB = LW / BW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] dfp_addr = '0;
    logic          dfp_read = 1'b0;
    logic          dfp_write = 1'b0;
    logic [LW-1:0] dfp_wdata = '0;
    logic [LW-1:0] dfp_rdata;
    logic          dfp_resp;
    logic [AW-1:0] bmem_addr;
    logic          bmem_read;
    logic          bmem_write;
    logic [BW-1:0] bmem_wdata;
    logic          bmem_ready = 1'b0;
    logic [BW-1:0] bmem_rdata = '0;
    logic          bmem_rvalid = 1'b0;

    icache_line_adapter #(
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW),
        .BURST_WIDTH(BW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic          is_read;
        logic [LW-1:0] line;
        int            start;
        int            lat;
    } resp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } beat_t;

    resp_t         resp_q[$];
    beat_t         wbeat_q[$];
    logic [AW-1:0] cmd_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected DUT activity (cycle %0d)", name, cyc);
    endtask

    // The cache controller never raises both requests at once.
    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(dfp_read && dfp_write)) else $error("dfp_read and dfp_write both high");
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (dfp_resp) begin
                if (resp_q.size() == 0) begin
                    flag("unexpected_resp");
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    chk("resp_latency", LW'(cyc - r.start), LW'(r.lat));
                    if (r.is_read) chk("rd_line", dfp_rdata, r.line);
                end
            end
            if (bmem_read && bmem_ready) begin
                if (cmd_q.size() == 0) begin
                    flag("unexpected_rd_cmd");
                end else begin
                    logic [AW-1:0] a;
                    a = cmd_q.pop_front();
                    chk("rd_cmd_addr", LW'(bmem_addr), LW'(a));
                end
            end
            if (bmem_write) begin
                if (wbeat_q.size() == 0) begin
                    flag("unexpected_wr_beat");
                end else if (bmem_ready) begin
                    beat_t b;
                    b = wbeat_q.pop_front();
                    chk("wr_beat_data", LW'(bmem_wdata), LW'(b.data));
                    chk("wr_beat_addr", LW'(bmem_addr), LW'(b.addr));
                end else begin
                    chk("wr_beat_held", LW'(bmem_wdata), LW'(wbeat_q[0].data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory returns the first beat in the cycle after command acceptance.
    // Read latency from the IDLE cycle: 6 + ready-low cycles + rvalid gaps.
    task automatic do_read(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                           input int nlow, input int gap_at);
        resp_t r;
        dfp_addr = addr;
        dfp_read = 1'b1;
        cmd_q.push_back(addr & ~32'h1F);
        r.is_read = 1'b1;
        r.line    = line;
        r.start   = cyc;
        r.lat     = 6 + nlow + ((gap_at >= 0) ? 1 : 0);
        resp_q.push_back(r);
        bmem_ready = 1'b0;
        step();
        for (int i = 0; i < nlow; i++) begin
            chk("rd_cmd_held", LW'(bmem_read), LW'(1));
            step();
        end
        bmem_ready = 1'b1;
        step();
        bmem_ready = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (b == gap_at) begin
                bmem_rvalid = 1'b0;
                step();
            end
            bmem_rvalid = 1'b1;
            bmem_rdata  = line[b*BW +: BW];
            step();
        end
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
        step();
        dfp_read = 1'b0;
    endtask

    // pat bit i is bmem_ready in the i-th WR_BEAT cycle; it must hold exactly NB ones
    // ending at bit plen-1, so resp lands at plen+1 cycles after the IDLE cycle.
    task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                            input logic [15:0] pat, input int plen, input bit stray);
        resp_t r;
        beat_t bt;
        dfp_addr  = addr;
        dfp_wdata = line;
        dfp_write = 1'b1;
        for (int b = 0; b < NB; b++) begin
            bt.addr = addr & ~32'h1F;
            bt.data = line[b*BW +: BW];
            wbeat_q.push_back(bt);
        end
        r.is_read = 1'b0;
        r.line    = '0;
        r.start   = cyc;
        r.lat     = plen + 1;
        resp_q.push_back(r);
        step();
        for (int i = 0; i < plen; i++) begin
            bmem_ready = pat[i];
            if (stray) begin
                bmem_rvalid = 1'b1;
                bmem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
            end
            step();
        end
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
        step();
        dfp_write = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dfp_resp"},   LW'(dfp_resp),   '0);
        chk({tag, "_bmem_read"},  LW'(bmem_read),  '0);
        chk({tag, "_bmem_write"}, LW'(bmem_write), '0);
        chk({tag, "_bmem_addr"},  LW'(bmem_addr),  '0);
        chk({tag, "_bmem_wdata"}, LW'(bmem_wdata), '0);
        chk({tag, "_dfp_rdata"},  dfp_rdata,       '0);
    endtask

    localparam logic [LW-1:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [LW-1:0] L2 = {64'h8888_0000_8888_0000, 64'h7777_0000_7777_0000,
                                    64'h6666_0000_6666_0000, 64'h5555_0000_5555_0000};
    localparam logic [LW-1:0] LWR = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                                     64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    localparam logic [LW-1:0] L3 = {64'h0303_0303_0303_0304, 64'h0303_0303_0303_0303,
                                    64'h0303_0303_0303_0302, 64'h0303_0303_0303_0301};
    localparam logic [LW-1:0] L4 = {64'h0404_0404_0404_0404, 64'h0404_0404_0404_0403,
                                    64'h0404_0404_0404_0402, 64'h0404_0404_0404_0401};
    localparam logic [LW-1:0] L5 = {64'hF0E1_D2C3_B4A5_9687, 64'h0123_4567_89AB_CDEF,
                                    64'hFEDC_BA98_7654_3210, 64'h1357_9BDF_2468_ACE0};
    localparam logic [LW-1:0] L6 = {64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555,
                                    64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333};

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Read, L=1, ready=1: resp 6 cycles after the IDLE cycle (7th cycle inclusive).
        do_read(32'h0000_1234, L1, 0, -1);

        // Stray rvalid while idle is ignored.
        for (int i = 0; i < 3; i++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            step();
            chk("idle_stray_rdata", dfp_rdata, L1);
            chk("idle_stray_noread", LW'(bmem_read), '0);
        end
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;

        // Ready low for 3 cycles, one rvalid gap before beat 2.
        do_read(32'h0000_2008, L2, 3, 2);

        // Write with ready 1,0,1,1,0,1 and stray rvalid throughout.
        do_write(32'h0000_0040, LWR, 16'b10_1101, 6, 1'b1);
        chk("wr_keeps_rdata", dfp_rdata, L2);

        // Back-to-back line fetches for a misaligned access.
        do_read(32'h0000_03E0, L3, 0, -1);
        do_read(32'h0000_0400, L4, 0, -1);
        step();

        // Reset during beat 2 of a read.
        dfp_addr = 32'h0000_0800;
        dfp_read = 1'b1;
        cmd_q.push_back(32'h0000_0800);
        step();
        bmem_ready = 1'b1;
        step();
        bmem_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = L5[b*BW +: BW];
            step();
        end
        bmem_rdata = L5[2*BW +: BW];
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        dfp_read = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bmem_rdata = L5[3*BW +: BW];
        step();
        step();
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
        chk("postreset_rdata", dfp_rdata, '0);
        chk("postreset_idle", LW'({bmem_read, bmem_write, dfp_resp}), '0);
        step();

        do_read(32'h0000_1000, L6, 0, -1);
        do_write(32'h0000_0080, L5, 16'b1111, 4, 1'b0);
        chk("wr2_keeps_rdata", dfp_rdata, L6);

        repeat (5) step();
        chk("resp_q_drained", LW'(resp_q.size()), '0);
        chk("cmd_q_drained", LW'(cmd_q.size()), '0);
        chk("wbeat_q_drained", LW'(wbeat_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
